stoch_decode: RTL and testbench
===============================

STOCH_DECODE -- requirements
Module: stoch_decode

Interface
REQ-001 Parameter: WINDOW_LOG2, default 8, legal 1..16; the decode window is 2^WINDOW_LOG2 bitstream samples.
REQ-002 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: nRST  input  1  reset; synchronous, active-low.
REQ-004 Port: start  input  1  request to begin one decode window; accepted only in IDLE.
REQ-005 Port: a  input  1  unipolar stochastic bitstream, one sample per cycle.
REQ-006 Port: ack  input  1  consumer acknowledge of the result; meaningful only in DONE.
REQ-007 Port: busy  output  1  high in ACCUM.
REQ-008 Port: valid  output  1  high in DONE; y is the result while high.
REQ-009 Port: y  output  WINDOW_LOG2+1  count of ones in the last completed window, range 0..2^WINDOW_LOG2.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE; busy and valid SHALL be registered, decoded from state only.
REQ-011 In IDLE with start=1, the block SHALL enter ACCUM next cycle and clear the ones counter and the sample counter.
REQ-012 The first sample SHALL be a in the first cycle in ACCUM; a in the start-acceptance cycle SHALL be ignored.
REQ-013 In ACCUM each cycle, the ones counter SHALL add a and the sample counter SHALL increment; both are WINDOW_LOG2+1 bits and SHALL never wrap.
REQ-014 On the cycle the 2^WINDOW_LOG2-th sample is taken, the block SHALL load y with ones-counter plus that a and enter DONE next cycle.
REQ-015 Latency: valid SHALL rise exactly 2^WINDOW_LOG2+1 cycles after the cycle in which start was accepted.
REQ-016 An all-ones window SHALL yield y = 2^WINDOW_LOG2 exactly, with no saturation or truncation.
REQ-017 In DONE, y and valid SHALL hold until ack=1; ack=1 in DONE SHALL move to IDLE, valid low the next cycle.
REQ-018 start in ACCUM or DONE SHALL be ignored and SHALL NOT be queued.
REQ-019 ack in IDLE or ACCUM SHALL be ignored.
REQ-020 start and ack together in DONE: ack SHALL take effect and start SHALL be ignored (unless REQ-026 applies).
REQ-021 y SHALL retain the last result in IDLE and ACCUM; it updates only at window completion.

Reset
REQ-022 When nRST=0 at a clock edge, the FSM SHALL enter IDLE and clear both counters.
REQ-023 Reset values: busy=0, valid=0, y=0.
REQ-024 Reset mid-ACCUM SHALL abandon the window; no partial result SHALL reach y.
REQ-025 start with nRST=0 SHALL be ignored; the first acceptable start is in the first cycle with nRST=1.

Configuration
REQ-026 With STOCH_DECODE_AUTORESTART_EN defined, ack=1 in DONE SHALL move directly to ACCUM with counters cleared, without needing start. valid drops and busy rises the next cycle. The first sample is a in that first ACCUM cycle.
REQ-027 Without STOCH_DECODE_AUTORESTART_EN, ack in DONE SHALL return to IDLE per REQ-017, and only start begins a new window.

Verification (WINDOW_LOG2=4)
REQ-028 Reset, start pulse, a=1 constant -> busy high 16 cycles, valid at start+17 cycles, y=16.
REQ-029 start, a alternating 1,0 from first ACCUM cycle -> y=8; a=0 constant -> y=0; ack -> valid low next cycle, y held.
REQ-030 start pulsed again mid-ACCUM and in DONE with ack held low 5 cycles -> window length unchanged, valid and y stable all 5 cycles, no second window.
REQ-031 nRST low for 1 cycle at sample 7 of a window -> busy=0, valid=0, y=0 next cycle; fresh start with a=1 -> y=16.
REQ-032 start and ack together in DONE -> IDLE, no new window; with STOCH_DECODE_AUTORESTART_EN, ack alone -> new window, busy high next cycle, y correct after 16 samples.

Source files
------------

// File: rtl/stoch_decode.sv
// stoch_decode: counts ones in a 2^WINDOW_LOG2-sample unipolar bitstream window.
// Define STOCH_DECODE_AUTORESTART_EN to begin the next window directly on ack.
module stoch_decode #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 a,
  input  logic                 ack,
  output logic                 busy,
  output logic                 valid,
  output logic [WINDOW_LOG2:0] y
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic [WINDOW_LOG2:0] LAST = {1'b0, {WINDOW_LOG2{1'b1}}};
  state_t state;
  logic [WINDOW_LOG2:0] ones, cnt, sum;
  assign sum = ones + {{WINDOW_LOG2{1'b0}}, a};
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      y     <= '0;
      ones  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          busy  <= 1'b1;
          ones  <= '0;
          cnt   <= '0;
        end
        ACCUM: begin
          ones <= sum;
          cnt  <= cnt + 1'b1;
          // last sample of the window goes straight into y, counters peak at 2^WINDOW_LOG2
          if (cnt == LAST) begin
            y     <= sum;
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        DONE: if (ack) begin
`ifdef STOCH_DECODE_AUTORESTART_EN
          state <= ACCUM;
          busy  <= 1'b1;
          valid <= 1'b0;
          ones  <= '0;
          cnt   <= '0;
`else
          state <= IDLE;
          valid <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stoch_decode.sv
// tb_stoch_decode: directed self-checking bench for stoch_decode with WINDOW_LOG2=4.
module tb_stoch_decode;
  logic       CLK, nRST, start, a, ack, busy, valid;
  logic [4:0] y;
  int checks = 0, errors = 0;

  stoch_decode #(.WINDOW_LOG2(4)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .a(a), .ack(ack),
    .busy(busy), .valid(valid), .y(y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 zeros, 1 ones, 2 alternating 1,0 with ack pulse, 3 ones with start pulse
  task automatic window(input string tag, input int mode, input int ey);
    int lat, nb, k;
    a = (mode == 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    nb = int'(busy);
    k = 0;
    while (!valid && lat < 40) begin
      a = (mode == 1 || mode == 3) ? 1'b1 : (mode == 2) ? ~k[0] : 1'b0;
      start = (mode == 3 && k == 5);
      ack = (mode == 2 && k == 3);
      k++;
      tick;
      lat++;
      nb += int'(busy);
    end
    start = 1'b0;
    ack = 1'b0;
    a = 1'b0;
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_busy_cycles"}, nb, 16);
    chk({tag, "_y"}, int'(y), ey);
    chk({tag, "_busy_done"}, int'(busy), 0);
  endtask

  task automatic ack_result(input int ey);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("ack_valid", int'(valid), 0);
    chk("ack_y_held", int'(y), ey);
`ifdef STOCH_DECODE_AUTORESTART_EN
    chk("ack_restart_busy", int'(busy), 1);
    nRST = 1'b0;
    tick;
    nRST = 1'b1;
`else
    chk("ack_idle_busy", int'(busy), 0);
`endif
  endtask

  initial begin
    nRST = 1'b0;
    start = 1'b1;
    a = 1'b1;
    ack = 1'b0;
    tick;
    tick;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_y", int'(y), 0);
    nRST = 1'b1;
    start = 1'b0;
    tick;
    chk("rst_start_ignored", int'(busy), 0);

    window("ones", 1, 16);
    chk("ones_valid", int'(valid), 1);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick;
      chk("hold_valid", int'(valid), 1);
      chk("hold_y", int'(y), 16);
    end
    start = 1'b0;
    ack_result(16);
    tick;
    chk("no_queued_start", int'(busy), 0);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("idle_ack_busy", int'(busy), 0);
    chk("idle_ack_valid", int'(valid), 0);

    window("zeros", 0, 0);
    ack_result(0);
    window("alt", 2, 8);
    ack_result(8);

    a = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    nRST = 1'b0;
    tick;
    nRST = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_y", int'(y), 0);
    a = 1'b0;
    tick;
    chk("midrst_idle", int'(busy), 0);

    window("fresh", 1, 16);
    ack_result(16);
    window("start_mid", 3, 16);

    start = 1'b1;
    ack = 1'b1;
    tick;
    start = 1'b0;
    ack = 1'b0;
    chk("start_ack_valid", int'(valid), 0);
`ifdef STOCH_DECODE_AUTORESTART_EN
    chk("auto_busy", int'(busy), 1);
    for (int i = 0; i < 16 && !valid; i++) begin
      a = (i % 2 == 0);
      tick;
    end
    a = 1'b0;
    chk("auto_valid", int'(valid), 1);
    chk("auto_y", int'(y), 8);
`else
    chk("start_ack_busy", int'(busy), 0);
    tick;
    chk("start_ack_no_window", int'(busy), 0);
    chk("start_ack_y_held", int'(y), 16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
